// File: rtl/onchip_memory_pkg.sv
// ---------------------------------------------------------------------------
// onchip_memory_pkg
//   Shared definitions for the on-chip memory controller:
//     - mem_state_e        : controller FSM state (CLEAR / READY)
//     - READ_LATENCY_MIN/MAX: legal read-latency values (1 and 2)
//     - read_latency_legal(): helper for parameter sanity checks
// ---------------------------------------------------------------------------
package onchip_memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,   // not accepting requests (reset / memory clear)
        ST_READY = 1'b1    // accepting requests whenever clken=1
    } mem_state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic bit read_latency_legal(input int lat);
        return (lat == READ_LATENCY_MIN) || (lat == READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/onchip_memory_array.sv
// ---------------------------------------------------------------------------
// onchip_memory_array
//   Byte-enabled single-port synchronous RAM, DATA_W x DEPTH.
//   The storage itself has no reset; only the read output register is reset.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-high reset of the read register only
//     we     in   write enable
//     be     in   BE_W   byte-lane enables for writes
//     addr   in   ADDR_W word address (shared by read and write)
//     wdata  in   DATA_W write data
//     re     in   read enable; q loads mem[addr] at the clock edge
//     q      out  DATA_W registered read data, holds while re=0
// ---------------------------------------------------------------------------
module onchip_memory_array #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/onchip_memory_ctrl.sv
// ---------------------------------------------------------------------------
// onchip_memory_ctrl
//   Avalon-style on-chip memory slave with clock enable, 1- or 2-cycle
//   pipelined reads, byte-enabled writes, optional write protection
//   (ROM_MODE) and a sticky write-violation flag.
//
//   Optional feature: define ONCHIP_MEMORY_CTRL_CLEAR_EN to zero the whole
//   memory (one word per enabled cycle) after every reset release before
//   requests are accepted.
//
//   Request semantics: a request is accepted in a cycle when chipselect=1,
//   (read|write)=1 and waitrequest=0 (waitrequest already includes ~clken).
//   read together with write is a write only. Each accepted read returns
//   exactly one readdatavalid beat READ_LATENCY enabled cycles later.
//
//   Ports:
//     clk           in   clock
//     reset         in   asynchronous active-high reset
//     clken         in   clock enable; 0 freezes all state
//     chipselect    in   slave select
//     read          in   read request
//     write         in   write request
//     address       in   ADDR_W word address
//     byteenable    in   BE_W   byte-lane write enables
//     writedata     in   DATA_W write data
//     debugaccess   in   debugger qualifier (allows writes when ROM_MODE=1)
//     readdata      out  DATA_W registered read data, holds between beats
//     readdatavalid out  read data beat
//     waitrequest   out  1 = request not accepted this cycle
//     wr_violation  out  sticky: blocked write seen since reset
// ---------------------------------------------------------------------------
module onchip_memory_ctrl
    import onchip_memory_pkg::*;
#(
    parameter  int DATA_W       = 16,
    parameter  int DEPTH        = 512,
    parameter  int READ_LATENCY = 1,
    parameter  int ROM_MODE     = 1,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] writedata,
    input  logic              debugaccess,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    output logic              wr_violation
);

    mem_state_e        state;
    mem_state_e        state_next;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic              wr_allowed;

    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    logic              valid_s1;

`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic              clear_last;

    assign clear_last = (clear_addr == ADDR_W'(DEPTH - 1));

    // Clear pointer restarts at 0 on every reset; it advances only while
    // the FSM is clearing with clken=1, and wraps back to 0 on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_addr <= '0;
        end else if (clear_we) begin
            clear_addr <= clear_addr + 1'b1;
        end
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else if (clken) begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: begin
`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
                if (clear_last) begin
                    state_next = ST_READY;
                end
`else
                state_next = ST_READY;
`endif
            end
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        waitrequest = (state == ST_CLEAR) | ~clken;
`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
        clear_we    = (state == ST_CLEAR) & clken;
`endif
    end

    // ---------------- request decode and RAM port mux ----------------
    always_comb begin
        accept     = chipselect & (read | write) & ~waitrequest;
        wr_accept  = accept & write;
        rd_accept  = accept & read & ~write;
        wr_allowed = (ROM_MODE == 0) | debugaccess;

        ram_we     = wr_accept & wr_allowed;
        ram_be     = byteenable;
        ram_addr   = address;
        ram_wdata  = writedata;
`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
        // No request can be accepted while clearing, so the clear port
        // owns the RAM outright during CLEAR.
        if (clear_we) begin
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_addr  = clear_addr;
            ram_wdata = '0;
        end
`endif
    end

    onchip_memory_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .re    (rd_accept),
        .q     (ram_q)
    );

    // ---------------- read pipeline ----------------
    // Stage 1 is the RAM output register; valid_s1 tracks it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_s1 <= 1'b0;
        end else if (clken) begin
            valid_s1 <= rd_accept;
        end
    end

    generate
        if (READ_LATENCY == READ_LATENCY_MIN) begin : g_lat1
            assign readdata      = ram_q;
            assign readdatavalid = valid_s1;
        end else begin : g_lat2
            logic [DATA_W-1:0] data_s2;
            logic              valid_s2;

            // Data only moves on a real beat so readdata holds in between.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_s2  <= '0;
                    valid_s2 <= 1'b0;
                end else if (clken) begin
                    valid_s2 <= valid_s1;
                    if (valid_s1) begin
                        data_s2 <= ram_q;
                    end
                end
            end

            assign readdata      = data_s2;
            assign readdatavalid = valid_s2;
        end
    endgenerate

    // ---------------- sticky write-violation flag ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_violation <= 1'b0;
        end else if (wr_accept & ~wr_allowed) begin
            wr_violation <= 1'b1;
        end
    end

endmodule

// File: tb/tb_onchip_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_onchip_memory_ctrl
//   Two controllers share one stimulus stream: dut1 uses the default
//   parameters (READ_LATENCY=1), dut2 uses READ_LATENCY=2. A behavioural
//   model (word array + expected-beat queues + ready countdown) predicts
//   waitrequest, wr_violation and every read beat, including its timing in
//   enabled cycles.
// ---------------------------------------------------------------------------
module tb_onchip_memory_ctrl;

    localparam int DW    = 16;
    localparam int DEP   = 512;
    localparam int AW    = 9;
    localparam int BW    = 2;
`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
    localparam int CLEAR_CYCLES = DEP;
`else
    localparam int CLEAR_CYCLES = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          clken;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [BW-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic          debugaccess;

    logic [DW-1:0] rd1, rd2;
    logic          rdv1, rdv2;
    logic          wait1, wait2;
    logic          viol1, viol2;

    onchip_memory_ctrl dut1 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .debugaccess   (debugaccess),
        .readdata      (rd1),
        .readdatavalid (rdv1),
        .waitrequest   (wait1),
        .wr_violation  (viol1)
    );

    onchip_memory_ctrl #(
        .DATA_W       (DW),
        .DEPTH        (DEP),
        .READ_LATENCY (2),
        .ROM_MODE     (1)
    ) dut2 (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .debugaccess   (debugaccess),
        .readdata      (rd2),
        .readdatavalid (rdv2),
        .waitrequest   (wait2),
        .wr_violation  (viol2)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] model_mem [DEP];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    int            due_q1[$];
    int            due_q2[$];
    logic [DW-1:0] last1, last2;
    logic [DW-1:0] d1, d2;
    int            due1, due2;
    int            ecount     = 0;
    int            clear_left = CLEAR_CYCLES;
    logic          exp_viol   = 1'b0;
    logic          exp_wait;

    // Outputs are sampled on the falling edge; the model then applies the
    // effect of the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_wait1", 32'(wait1), 32'd1);
            check("rst_wait2", 32'(wait2), 32'd1);
            check("rst_rdv1",  32'(rdv1),  32'd0);
            check("rst_rdv2",  32'(rdv2),  32'd0);
            check("rst_rd1",   32'(rd1),   32'd0);
            check("rst_rd2",   32'(rd2),   32'd0);
            check("rst_viol1", 32'(viol1), 32'd0);
            check("rst_viol2", 32'(viol2), 32'd0);
            exp_q1.delete();
            exp_q2.delete();
            due_q1.delete();
            due_q2.delete();
            last1      = '0;
            last2      = '0;
            exp_viol   = 1'b0;
            clear_left = CLEAR_CYCLES;
`ifdef ONCHIP_MEMORY_CTRL_CLEAR_EN
            for (int i = 0; i < DEP; i++) model_mem[i] = '0;
`endif
        end else begin
            exp_wait = (clear_left != 0) || !clken;
            check("wait1", 32'(wait1), 32'(exp_wait));
            check("wait2", 32'(wait2), 32'(exp_wait));
            check("viol1", 32'(viol1), 32'(exp_viol));
            check("viol2", 32'(viol2), 32'(exp_viol));

            if (rdv1 && clken) begin
                if (exp_q1.size() == 0) begin
                    check("spurious_rdv1", 32'd1, 32'd0);
                end else begin
                    d1   = exp_q1.pop_front();
                    due1 = due_q1.pop_front();
                    check("rdata1", 32'(rd1), 32'(d1));
                    check("lat1", 32'(ecount), 32'(due1));
                    last1 = d1;
                end
            end else if (!rdv1) begin
                check("hold1", 32'(rd1), 32'(last1));
            end

            if (rdv2 && clken) begin
                if (exp_q2.size() == 0) begin
                    check("spurious_rdv2", 32'd1, 32'd0);
                end else begin
                    d2   = exp_q2.pop_front();
                    due2 = due_q2.pop_front();
                    check("rdata2", 32'(rd2), 32'(d2));
                    check("lat2", 32'(ecount), 32'(due2));
                    last2 = d2;
                end
            end else if (!rdv2) begin
                check("hold2", 32'(rd2), 32'(last2));
            end

            if (!exp_wait && chipselect) begin
                if (write) begin
                    if (debugaccess) begin
                        for (int i = 0; i < BW; i++) begin
                            if (byteenable[i]) model_mem[address][8*i +: 8] = writedata[8*i +: 8];
                        end
                    end else begin
                        exp_viol = 1'b1;
                    end
                end else if (read) begin
                    exp_q1.push_back(model_mem[address]);
                    exp_q2.push_back(model_mem[address]);
                    due_q1.push_back(ecount + 1);
                    due_q2.push_back(ecount + 2);
                end
            end

            if (clken) begin
                ecount++;
                if (clear_left != 0) clear_left--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drv_cycle(input logic cs, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [BW-1:0] be,
                             input logic [DW-1:0] wd, input logic dbg, input logic ce);
        chipselect  = cs;
        read        = rd;
        write       = wr;
        address     = a;
        byteenable  = be;
        writedata   = wd;
        debugaccess = dbg;
        clken       = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic dbg);
        drv_cycle(1'b1, 1'b0, 1'b1, a, be, wd, dbg, 1'b1);
    endtask

    task automatic rd_op(input logic [AW-1:0] a);
        drv_cycle(1'b1, 1'b1, 1'b0, a, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle_op(input int n);
        for (int i = 0; i < n; i++) drv_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic wait_ready();
        int budget;
        budget = 0;
        while (wait1 && budget < 2000) begin
            idle_op(1);
            budget++;
        end
        check("ready_reached", 32'(wait1), 32'd0);
    endtask

    function automatic logic [AW-1:0] win_addr(input int idx);
        logic [AW-1:0] base;
        base = (idx >= 32) ? AW'(9'h1E0) : AW'(0);
        return base | AW'(idx % 32);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        clken       = 1'b1;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = '0;
        byteenable  = '0;
        writedata   = '0;
        debugaccess = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready();

        // Preload the 64-word working window so every read has a known value.
        for (int i = 0; i < 64; i++) wr_op(win_addr(i), DW'($urandom), 2'b11, 1'b1);
        idle_op(2);

        // Simple write then read back.
        wr_op(9'd5, 16'hBEEF, 2'b11, 1'b1);
        rd_op(9'd5);
        idle_op(3);

        // Byte-lane merge.
        wr_op(9'd3, 16'hAAAA, 2'b11, 1'b1);
        wr_op(9'd3, 16'h5500, 2'b10, 1'b1);
        rd_op(9'd3);
        wr_op(9'd3, 16'hFFFF, 2'b00, 1'b1);
        rd_op(9'd3);
        idle_op(3);

        // Back-to-back reads.
        wr_op(9'd0, 16'h0011, 2'b11, 1'b1);
        wr_op(9'd1, 16'h0022, 2'b11, 1'b1);
        wr_op(9'd2, 16'h0033, 2'b11, 1'b1);
        rd_op(9'd0);
        rd_op(9'd1);
        rd_op(9'd2);
        idle_op(4);

        // Read together with write is a write.
        drv_cycle(1'b1, 1'b1, 1'b1, 9'd4, 2'b11, 16'h4444, 1'b1, 1'b1);
        rd_op(9'd4);
        idle_op(3);

        // Blocked write without debugaccess.
        wr_op(9'd7, 16'h1234, 2'b11, 1'b0);
        rd_op(9'd7);
        idle_op(3);

        // Clock-enable stall in the middle of a read stream.
        rd_op(9'd0);
        rd_op(9'd1);
        rd_op(9'd2);
        for (int i = 0; i < 3; i++) drv_cycle(1'b1, 1'b1, 1'b0, 9'd3, '0, '0, 1'b0, 1'b0);
        rd_op(9'd3);
        rd_op(9'd4);
        rd_op(9'd5);
        idle_op(4);

        // Reset in the cycle after a read is accepted; also clears the flag.
        rd_op(9'd9);
        reset = 1'b1;
        idle_op(2);
        reset = 1'b0;
        wait_ready();
        idle_op(4);
        rd_op(9'd5);
        idle_op(3);

        // Randomized traffic over the working window.
        for (int n = 0; n < 600; n++) begin
            int op;
            op = $urandom_range(0, 3);
            drv_cycle(($urandom_range(0, 7) != 0), (op == 1 || op == 3), (op >= 2),
                      win_addr($urandom_range(0, 63)), BW'($urandom_range(0, 3)),
                      DW'($urandom), ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 9) != 0));
        end
        idle_op(6);

        check("drain1", 32'(exp_q1.size()), 32'd0);
        check("drain2", 32'(exp_q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
